// File: rtl/hs_upload_source.sv
// ---------------------------------------------------------------------------
// hs_upload_source
//
// Serves a window of game work RAM (the hiscore table) to the HPS over the
// ioctl upload channel. It is the upload-side counterpart of the ROM/DIP
// download path: hps_io strobes byte offsets, this block pauses the game CPU,
// reads the byte from the hiscore RAM port and hands it back on ioctl_din.
//
// Optional feature macro: HS_UPLOAD_CHECKSUM_EN
//   When defined, bytes returned for offsets below LEN are summed (mod 256)
//   and a read of offset LEN returns the one's complement of that sum.
//   When undefined, offset LEN behaves like any other out-of-window offset.
//
// Ports
//   clk           in   system clock (clk_sys domain)
//   reset_n       in   asynchronous active-low reset
//   save_trigger  in   one-cycle pulse requesting an upload (autosave / OSD)
//   ioctl_upload  in   HPS upload in progress
//   ioctl_rd      in   one-cycle read strobe from the HPS
//   ioctl_index   in   selected upload slot
//   ioctl_addr    in   byte offset being read
//   ioctl_din     out  byte returned to the HPS
//   upload_req    out  upload request towards hps_io
//   pause_cpu     out  request to hold the game CPU
//   cpu_paused    in   CPU hold acknowledge
//   ram_addr      out  game RAM read address
//   ram_dout      in   game RAM read data
//   busy          out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module hs_upload_source #(
   parameter int unsigned          ADDR_W       = 16,
   parameter int unsigned          LEN          = 64,
   parameter logic [ADDR_W-1:0]    BASE_ADDR    = 16'h8A00,
   parameter int unsigned          RAM_LATENCY  = 1,
   parameter logic [7:0]           UPLOAD_INDEX = 8'd4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              save_trigger,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              upload_req,
   output logic              pause_cpu,
   input  logic              cpu_paused,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_dout,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_REQ        = 3'd1,
      ST_ACTIVE     = 3'd2,
      ST_WAIT_PAUSE = 3'd3,
      ST_FETCH      = 3'd4,
      ST_RELEASE    = 3'd5
   } state_t;

   localparam logic [1:0]  LAT_LAST = 2'(RAM_LATENCY);
   localparam logic [31:0] LEN_W    = 32'(LEN);

   state_t            state_q,    state_d;
   logic [7:0]        ioctl_din_q, ioctl_din_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
   logic [1:0]        lat_cnt_q,  lat_cnt_d;
`ifdef HS_UPLOAD_CHECKSUM_EN
   logic [7:0]        sum_q,      sum_d;
`endif

   logic              sel;
   logic [31:0]       addr_ext;
   logic              addr_in_window;

   assign sel            = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
   assign addr_ext       = {7'd0, ioctl_addr};
   assign addr_in_window = (addr_ext < LEN_W);

   // State and datapath registers; reset aborts any upload in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ioctl_din_q <= 8'hFF;
         ram_addr_q  <= BASE_ADDR;
         rd_addr_q   <= '0;
         lat_cnt_q   <= 2'd0;
`ifdef HS_UPLOAD_CHECKSUM_EN
         sum_q       <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         ioctl_din_q <= ioctl_din_d;
         ram_addr_q  <= ram_addr_d;
         rd_addr_q   <= rd_addr_d;
         lat_cnt_q   <= lat_cnt_d;
`ifdef HS_UPLOAD_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   // Next-state and datapath logic.
   // The requested offset is latched on the strobe so that a read stalled in
   // WAIT_PAUSE still fetches the right byte even if ioctl_addr moves on.
   // Strobes seen outside ACTIVE are dropped; a falling sel during a fetch
   // lets the fetch complete and is acted on once back in ACTIVE.
   always_comb begin
      state_d     = state_q;
      ioctl_din_d = ioctl_din_q;
      ram_addr_d  = ram_addr_q;
      rd_addr_d   = rd_addr_q;
      lat_cnt_d   = lat_cnt_q;
`ifdef HS_UPLOAD_CHECKSUM_EN
      sum_d       = sum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (sel) begin
               state_d = ST_ACTIVE;
            end else if (save_trigger) begin
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            if (sel) begin
               state_d = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            if (!sel) begin
               state_d = ST_RELEASE;
            end else if (ioctl_rd) begin
               if (addr_in_window) begin
                  rd_addr_d = ioctl_addr[ADDR_W-1:0];
                  if (cpu_paused) begin
                     ram_addr_d = BASE_ADDR + ioctl_addr[ADDR_W-1:0];
                     lat_cnt_d  = 2'd0;
                     state_d    = ST_FETCH;
                  end else begin
                     state_d = ST_WAIT_PAUSE;
                  end
               end else begin
`ifdef HS_UPLOAD_CHECKSUM_EN
                  if (addr_ext == LEN_W) begin
                     ioctl_din_d = ~sum_q;
                  end else begin
                     ioctl_din_d = 8'hFF;
                  end
`else
                  ioctl_din_d = 8'hFF;
`endif
               end
            end
         end

         ST_WAIT_PAUSE: begin
            if (cpu_paused) begin
               ram_addr_d = BASE_ADDR + rd_addr_q;
               lat_cnt_d  = 2'd0;
               state_d    = ST_FETCH;
            end
         end

         // ram_addr was registered on entry; data is captured once the RAM
         // has had RAM_LATENCY cycles to respond.
         ST_FETCH: begin
            if (lat_cnt_q == LAT_LAST) begin
               ioctl_din_d = ram_dout;
`ifdef HS_UPLOAD_CHECKSUM_EN
               if (rd_addr_q == '0) begin
                  sum_d = ram_dout;
               end else begin
                  sum_d = sum_q + ram_dout;
               end
`endif
               state_d = ST_ACTIVE;
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end

         ST_RELEASE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control outputs decode straight from state so a reset clears them
   // immediately rather than on the next clock edge.
   assign upload_req = (state_q == ST_REQ);
   assign pause_cpu  = (state_q == ST_ACTIVE) ||
                       (state_q == ST_WAIT_PAUSE) ||
                       (state_q == ST_FETCH);
   assign busy       = (state_q != ST_IDLE);
   assign ioctl_din  = ioctl_din_q;
   assign ram_addr   = ram_addr_q;

endmodule

// File: tb/tb_hs_upload_source.sv
// ---------------------------------------------------------------------------
// tb_hs_upload_source
//
// Directed bench for hs_upload_source with default parameters. The game RAM
// is modelled as a one-cycle synchronous read whose window 8A00..8A3F holds
// the byte equal to its offset (00..3F). Expectation for offset LEN depends
// on whether HS_UPLOAD_CHECKSUM_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_hs_upload_source;

   logic        clk;
   logic        reset_n;
   logic        save_trigger;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        upload_req;
   logic        pause_cpu;
   logic        cpu_paused;
   logic [15:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        busy;

   int n_compared   = 0;
   int n_mismatched = 0;

   hs_upload_source dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .save_trigger (save_trigger),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_index  (ioctl_index),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .upload_req   (upload_req),
      .pause_cpu    (pause_cpu),
      .cpu_paused   (cpu_paused),
      .ram_addr     (ram_addr),
      .ram_dout     (ram_dout),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle synchronous RAM: window bytes equal their offset.
   always @(posedge clk) begin
      if (ram_addr >= 16'h8A00 && ram_addr <= 16'h8A3F) begin
         ram_dout <= ram_addr[7:0];
      end else begin
         ram_dout <= 8'hA5;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One HPS read strobe followed by enough idle cycles for the byte to land.
   task automatic apply_stimulus(input logic [24:0] addr);
      ioctl_addr = addr;
      ioctl_rd   = 1'b1;
      @(posedge clk); #1;
      ioctl_rd   = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [7:0] exp_len_byte;
`ifdef HS_UPLOAD_CHECKSUM_EN
      exp_len_byte = 8'h1F;
`else
      exp_len_byte = 8'hFF;
`endif
      reset_n      = 1'b0;
      save_trigger = 1'b0;
      ioctl_upload = 1'b0;
      ioctl_rd     = 1'b0;
      ioctl_index  = 8'd0;
      ioctl_addr   = 25'd0;
      cpu_paused   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_din",      ioctl_din,  8'hFF);
      check_output("rst_req",      upload_req, 1'b0);
      check_output("rst_pause",    pause_cpu,  1'b0);
      check_output("rst_busy",     busy,       1'b0);
      check_output("rst_ram_addr", ram_addr,   16'h8A00);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Upload for another slot must be ignored.
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd3;
      apply_stimulus(25'd5);
      check_output("idx3_pause", pause_cpu,  1'b0);
      check_output("idx3_req",   upload_req, 1'b0);
      check_output("idx3_busy",  busy,       1'b0);
      check_output("idx3_din",   ioctl_din,  8'hFF);
      ioctl_upload = 1'b0;
      ioctl_index  = 8'd0;
      @(posedge clk); #1;

      // Core-initiated save: request held until the HPS selects our slot.
      save_trigger = 1'b1;
      @(posedge clk); #1;
      save_trigger = 1'b0;
      check_output("req_set",   upload_req, 1'b1);
      check_output("req_busy",  busy,       1'b1);
      check_output("req_pause", pause_cpu,  1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_output("req_hold", upload_req, 1'b1);
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd4;
      @(posedge clk); #1;
      check_output("act_req",   upload_req, 1'b0);
      check_output("act_pause", pause_cpu,  1'b1);

      // Read offset 5 with the CPU already held: byte lands two edges later.
      cpu_paused = 1'b1;
      ioctl_addr = 25'd5;
      ioctl_rd   = 1'b1;
      @(posedge clk); #1;
      ioctl_rd   = 1'b0;
      check_output("rd5_ram_addr", ram_addr,  16'h8A05);
      check_output("rd5_din_e0",   ioctl_din, 8'hFF);
      @(posedge clk); #1;
      check_output("rd5_din_e1",   ioctl_din, 8'hFF);
      @(posedge clk); #1;
      check_output("rd5_din_e2",   ioctl_din, 8'h05);
      repeat (6) begin
         @(posedge clk); #1;
      end

      // Offset beyond the window and the checksum slot returns FF next cycle.
      ioctl_addr = 25'd70;
      ioctl_rd   = 1'b1;
      @(posedge clk); #1;
      ioctl_rd   = 1'b0;
      check_output("rd70_din",      ioctl_din, 8'hFF);
      check_output("rd70_ram_addr", ram_addr,  16'h8A05);
      repeat (6) begin
         @(posedge clk); #1;
      end

      // Read offset 0 while the CPU has not yet acknowledged the hold.
      cpu_paused = 1'b0;
      ioctl_addr = 25'd0;
      ioctl_rd   = 1'b1;
      @(posedge clk); #1;
      ioctl_rd   = 1'b0;
      ioctl_addr = 25'd9;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check_output("wait_ram_addr", ram_addr,  16'h8A05);
      check_output("wait_pause",    pause_cpu, 1'b1);
      check_output("wait_din",      ioctl_din, 8'hFF);
      cpu_paused = 1'b1;
      @(posedge clk); #1;
      check_output("ack_ram_addr", ram_addr,  16'h8A00);
      @(posedge clk); #1;
      check_output("ack_din_e1",   ioctl_din, 8'hFF);
      @(posedge clk); #1;
      check_output("ack_din_e2",   ioctl_din, 8'h00);
      repeat (6) begin
         @(posedge clk); #1;
      end

      // Full sequential sweep, then the checksum slot and one beyond it.
      for (int i = 0; i < 64; i++) begin
         apply_stimulus(25'(i));
         check_output($sformatf("sweep_%0d", i), ioctl_din, 32'(i));
      end
      apply_stimulus(25'd64);
      check_output("len_byte", ioctl_din, exp_len_byte);
      apply_stimulus(25'd65);
      check_output("len_plus1", ioctl_din, 8'hFF);

      // sel drops mid-fetch: the fetch completes, then the hold is released.
      ioctl_addr = 25'd10;
      ioctl_rd   = 1'b1;
      @(posedge clk); #1;
      ioctl_rd     = 1'b0;
      ioctl_upload = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_output("drop_din",   ioctl_din, 8'h0A);
      check_output("drop_pause", pause_cpu, 1'b1);
      @(posedge clk); #1;
      check_output("rel_pause",  pause_cpu, 1'b0);
      check_output("rel_busy",   busy,      1'b1);
      @(posedge clk); #1;
      check_output("idle_busy",  busy,      1'b0);

      // HPS-initiated upload, reset asserted while a fetch is in flight.
      ioctl_upload = 1'b1;
      @(posedge clk); #1;
      check_output("hps_pause", pause_cpu, 1'b1);
      ioctl_addr = 25'd3;
      ioctl_rd   = 1'b1;
      @(posedge clk); #1;
      ioctl_rd   = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_output("arst_pause",    pause_cpu,  1'b0);
      check_output("arst_req",      upload_req, 1'b0);
      check_output("arst_din",      ioctl_din,  8'hFF);
      check_output("arst_busy",     busy,       1'b0);
      check_output("arst_ram_addr", ram_addr,   16'h8A00);
      ioctl_upload = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      save_trigger = 1'b1;
      @(posedge clk); #1;
      save_trigger = 1'b0;
      check_output("post_rst_req", upload_req, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
